seq_divider: RTL

//   Multi-cycle restoring divider that feeds the ALU divide path. It produces the

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 32 +++
 rtl/seq_divider.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Optional feature macro: DIV_SIGNED_EN (signed division support in seq_divider).
package div_pkg;

   // Controller states; the 2-bit encoding leaves one unused code that recovers to IDLE
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Default operand/result width
   localparam int DIV_WIDTH = 32;

   // Divide-by-zero quotient: every bit set (replicated to the instance width)
   localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

   // Step counter width; one spare bit so WIDTH itself is representable
   function automatic int div_cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the partial remainder, trial-subtract the divisor, keep the
// difference only when it is non-negative, and record the quotient bit.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH:0]   o_rem,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_diff;

   // Shift, trial subtract, then restore or accept based on the borrow bit
   always_comb begin
      w_shift = {i_rem, i_q[WIDTH-1]};
      w_diff  = w_shift - {2'b00, i_divisor};
      if (!w_diff[WIDTH+1]) begin
         o_rem = w_diff[WIDTH:0];
         o_q   = {i_q[WIDTH-2:0], 1'b1};
      end else begin
         o_rem = w_shift[WIDTH:0];
         o_q   = {i_q[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for the ALU divide path: quotient goes to
// zLOW, remainder to zHI, one quotient bit is resolved per clock.
// Handshake: start is sampled only in IDLE or DONE; busy is high for the
// whole RUN phase; done pulses for exactly one cycle when quotient,
// remainder and div_zero are freshly written, and those outputs then hold
// until the next result write or reset.
// Optional feature macro: DIV_SIGNED_EN adds the sgn port and truncating
// signed division; without it all operations are unsigned.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
   input  logic             sgn,
`endif
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output div_state_t       dbg_state
);

   localparam int CW = div_cnt_w(WIDTH);

   div_state_t       r_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero;
   logic             r_neg_q;
   logic             r_neg_r;

   logic [WIDTH:0]   w_rem_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_neg_q;
   logic             w_neg_r;
   logic [WIDTH-1:0] w_q_fin;
   logic [WIDTH-1:0] w_r_fin;
   logic [WIDTH-1:0] w_div0_q;

   assign w_div0_q = {WIDTH{DIV0_QUOTIENT[0]}};

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .i_rem     (r_rem),
      .i_q       (r_q),
      .i_divisor (r_div),
      .o_rem     (w_rem_nxt),
      .o_q       (w_q_nxt)
   );

   // Operand magnitudes at start and sign fix-up of the final step's result
   always_comb begin
`ifdef DIV_SIGNED_EN
      w_neg_r = sgn & dividend[WIDTH-1];
      w_neg_q = w_neg_r ^ (sgn & divisor[WIDTH-1]);
      w_a_mag = w_neg_r ? (~dividend + 1'b1) : dividend;
      w_b_mag = (sgn & divisor[WIDTH-1]) ? (~divisor + 1'b1) : divisor;
      w_q_fin = r_neg_q ? (~w_q_nxt + 1'b1) : w_q_nxt;
      w_r_fin = r_neg_r ? (~w_rem_nxt[WIDTH-1:0] + 1'b1) : w_rem_nxt[WIDTH-1:0];
`else
      w_neg_r = 1'b0;
      w_neg_q = 1'b0;
      w_a_mag = dividend;
      w_b_mag = divisor;
      w_q_fin = w_q_nxt;
      w_r_fin = w_rem_nxt[WIDTH-1:0];
`endif
   end

   // Controller FSM with counter, work registers and registered outputs
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_rem       <= '0;
         r_q         <= '0;
         r_div       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div_zero  <= 1'b0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
               if (start) begin
                  if (divisor != '0) begin
                     r_rem   <= '0;
                     r_q     <= w_a_mag;
                     r_div   <= w_b_mag;
                     r_neg_q <= w_neg_q;
                     r_neg_r <= w_neg_r;
                     r_count <= '0;
                     r_busy  <= 1'b1;
                     r_state <= RUN;
                  end else begin
                     // Divide-by-zero resolves immediately, identical for signed ops
                     r_quotient  <= w_div0_q;
                     r_remainder <= dividend;
                     r_div_zero  <= 1'b1;
                     r_done      <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            RUN: begin
               r_rem   <= w_rem_nxt;
               r_q     <= w_q_nxt;
               r_count <= r_count + 1'b1;
               // The WIDTH-th step writes its own outputs straight to the result registers
               if (r_count == CW'(WIDTH - 1)) begin
                  r_quotient  <= w_q_fin;
                  r_remainder <= w_r_fin;
                  r_div_zero  <= 1'b0;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= DONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign busy      = r_busy;
   assign done      = r_done;
   assign div_zero  = r_div_zero;
   assign dbg_state = r_state;

endmodule
